// File: rtl/branch_fetch_sequencer_pkg.sv
// Shared opcodes, FSM encoding and PC increment for the branch fetch sequencer.
package branch_fetch_sequencer_pkg;

  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam int         PC_STEP = 4;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_WAIT   = 2'd1,
    ST_REFILL = 2'd2
  } seq_state_t;

  function automatic logic is_branch(input logic [5:0] opcode);
    return (opcode == OP_BEQ) || (opcode == OP_J);
  endfunction

endpackage

// File: rtl/branch_fetch_sequencer_sat_counter.sv
// Saturating event counter; freezes under hold and sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             hold,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !hold && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/branch_fetch_sequencer.sv
// Fetch PC owner: issues a branch, bubbles until it resolves, then absorbs one refill cycle.
//
// state  | meaning
// RUN    | fetching and issuing sequential words
// WAIT   | branch in flight, inserting bubbles until resolve or timeout
// REFILL | redirect taken; the word in flight is from the stale address
module branch_fetch_sequencer
  import branch_fetch_sequencer_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 8,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       fetch_opcode,
  input  logic             fetch_valid,
  input  logic             hold,
  input  logic             resolve_valid,
  input  logic             resolve_taken,
  input  logic [PC_W-1:0]  resolve_target,
  output logic [PC_W-1:0]  pc,
  output logic             issue_valid,
  output logic [1:0]       state_dbg,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             timeout_err
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  seq_state_t        state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_err_q, timeout_err_d;
  logic              branch_inc;
  logic              stall_inc;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;
    branch_inc    = 1'b0;
    stall_inc     = 1'b0;
    if (!hold) begin
      unique case (state_q)
        ST_RUN: begin
          if (fetch_valid) begin
            pc_d = pc_q + PC_W'(PC_STEP);
            if (is_branch(fetch_opcode)) begin
              branch_inc = 1'b1;
              wait_cnt_d = '0;
              state_d    = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          stall_inc = 1'b1;
          // Resolve beats the timeout boundary; pc already holds the fall-through.
          if (resolve_valid) begin
            if (resolve_taken) begin
              pc_d = resolve_target;
            end
            state_d = ST_REFILL;
          end else if (wait_cnt_q == WAIT_LAST) begin
            timeout_err_d = 1'b1;
            state_d       = ST_RUN;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
        ST_REFILL: begin
          stall_inc = 1'b1;
          state_d   = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (branch_inc),
    .hold  (hold),
    .count (branch_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .hold  (hold),
    .count (stall_cnt)
  );

  assign pc          = pc_q;
  assign state_dbg   = state_q;
  assign timeout_err = timeout_err_q;
  assign issue_valid = (state_q == ST_RUN) && fetch_valid && !hold && !rst;

endmodule

// File: tb/tb_branch_fetch_sequencer.sv
// Directed bench for branch_fetch_sequencer with a per-cycle scoreboard of expected outputs.
module tb_branch_fetch_sequencer;

  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] J   = 6'b000010;
  localparam logic [5:0] ADD = 6'b000000;
  localparam logic [5:0] BNE = 6'b000101;
  localparam logic [5:0] LW  = 6'b100011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  fetch_opcode = '0;
  logic        fetch_valid = 1'b0;
  logic        hold = 1'b0;
  logic        resolve_valid = 1'b0;
  logic        resolve_taken = 1'b0;
  logic [31:0] resolve_target = '0;
  logic [31:0] pc;
  logic        issue_valid;
  logic [1:0]  state_dbg;
  logic [3:0]  branch_cnt;
  logic [3:0]  stall_cnt;
  logic        timeout_err;

  branch_fetch_sequencer #(
    .PC_W(32), .RESET_PC(32'h0), .TIMEOUT(8), .CNT_W(4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_opcode   (fetch_opcode),
    .fetch_valid    (fetch_valid),
    .hold           (hold),
    .resolve_valid  (resolve_valid),
    .resolve_taken  (resolve_taken),
    .resolve_target (resolve_target),
    .pc             (pc),
    .issue_valid    (issue_valid),
    .state_dbg      (state_dbg),
    .branch_cnt     (branch_cnt),
    .stall_cnt      (stall_cnt),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        issue;
    logic [1:0]  st;
    logic [3:0]  bc;
    logic [3:0]  sc;
    logic        terr;
  } exp_t;

  exp_t sb[$];
  int n_assert = 0;
  int n_fail   = 0;

  // Reference model of the architectural state
  int          m_st;
  logic [31:0] m_pc;
  int          m_wait;
  logic        m_terr;
  int          m_bc;
  int          m_sc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_pc = 32'h0; m_wait = 0; m_terr = 1'b0; m_bc = 0; m_sc = 0;
  endtask

  task automatic model_clock(input logic fv, input logic [5:0] op, input logic h,
                             input logic rv, input logic rt, input logic [31:0] tgt);
    if (h) return;
    if (m_st == 0) begin
      if (fv) begin
        m_pc = m_pc + 32'd4;
        if (op == BEQ || op == J) begin
          if (m_bc < 15) m_bc++;
          m_wait = 0;
          m_st = 1;
        end
      end
    end else if (m_st == 1) begin
      if (m_sc < 15) m_sc++;
      if (rv) begin
        if (rt) m_pc = tgt;
        m_st = 2;
      end else if (m_wait == 7) begin
        m_terr = 1'b1;
        m_st = 0;
      end else begin
        m_wait++;
      end
    end else begin
      if (m_sc < 15) m_sc++;
      m_st = 0;
    end
  endtask

  // One clock: drive at negedge, score mid-cycle, advance model at posedge.
  task automatic step(input string tag, input logic fv, input logic [5:0] op, input logic h,
                      input logic rv, input logic rt, input logic [31:0] tgt);
    exp_t e;
    fetch_valid = fv; fetch_opcode = op; hold = h;
    resolve_valid = rv; resolve_taken = rt; resolve_target = tgt;
    e.tag = tag; e.pc = m_pc; e.issue = (m_st == 0) && fv && !h;
    e.st = 2'(m_st); e.bc = 4'(m_bc); e.sc = 4'(m_sc); e.terr = m_terr;
    sb.push_back(e);
    #2;
    e = sb.pop_front();
    chk({e.tag, "_pc"}, pc, e.pc);
    chk({e.tag, "_issue"}, 32'(issue_valid), 32'(e.issue));
    chk({e.tag, "_state"}, 32'(state_dbg), 32'(e.st));
    chk({e.tag, "_bcnt"}, 32'(branch_cnt), 32'(e.bc));
    chk({e.tag, "_scnt"}, 32'(stall_cnt), 32'(e.sc));
    chk({e.tag, "_terr"}, 32'(timeout_err), 32'(e.terr));
    @(posedge clk);
    model_clock(fv, op, h, rv, rt, tgt);
    @(negedge clk);
  endtask

  // Asynchronous reset pulse mid-cycle, checked before the next clock edge.
  task automatic do_reset(input string tag);
    #3;
    fetch_valid = 1'b1; fetch_opcode = ADD; hold = 1'b0; resolve_valid = 1'b1;
    rst = 1'b1;
    #1;
    model_reset();
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_issue"}, 32'(issue_valid), 32'h0);
    chk({tag, "_state"}, 32'(state_dbg), 32'h0);
    chk({tag, "_bcnt"}, 32'(branch_cnt), 32'h0);
    chk({tag, "_scnt"}, 32'(stall_cnt), 32'h0);
    chk({tag, "_terr"}, 32'(timeout_err), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    resolve_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before the end of the test");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    @(negedge clk);
    do_reset("rst0");

    // Sequential words, including a near-miss branch opcode
    for (int i = 0; i < 5; i++) step("s1_seq", 1, (i % 2) ? LW : BNE, 0, 0, 0, 32'h0);
    step("s1_idle", 0, ADD, 0, 0, 0, 32'h0);
    chk("s1_pc20", pc, 32'd20);
    step("s1_spur", 0, ADD, 0, 1, 1, 32'h100);
    chk("s1_spur_pc", pc, 32'd20);
    chk("s1_spur_state", 32'(state_dbg), 32'd0);

    // beq at 8, taken to 0x40 on the third WAIT cycle
    do_reset("s2_rst");
    step("s2_seq", 1, ADD, 0, 0, 0, 32'h0);
    step("s2_seq", 1, ADD, 0, 0, 0, 32'h0);
    step("s2_beq", 1, BEQ, 0, 0, 0, 32'h0);
    step("s2_w1", 1, ADD, 0, 0, 0, 32'h0);
    step("s2_w2", 1, ADD, 0, 0, 0, 32'h0);
    step("s2_w3", 1, ADD, 0, 1, 1, 32'h40);
    step("s2_ref", 1, ADD, 0, 0, 0, 32'h0);
    chk("s2_pc40", pc, 32'h40);
    chk("s2_bcnt1", 32'(branch_cnt), 32'd1);
    chk("s2_scnt4", 32'(stall_cnt), 32'd4);
    step("s2_run", 1, ADD, 0, 0, 0, 32'h0);

    // j at 0, not taken; then a taken branch to the top of memory to check wrap
    do_reset("s3_rst");
    step("s3_j", 1, J, 0, 0, 0, 32'h0);
    step("s3_w1", 1, ADD, 0, 0, 0, 32'h0);
    step("s3_w2", 1, ADD, 0, 1, 0, 32'h99);
    step("s3_ref", 1, ADD, 0, 0, 0, 32'h0);
    chk("s3_pc4", pc, 32'h4);
    step("s3_run", 1, ADD, 0, 0, 0, 32'h0);
    chk("s3_pc8", pc, 32'h8);
    step("s3_beq", 1, BEQ, 0, 0, 0, 32'h0);
    step("s3_top", 1, ADD, 0, 1, 1, 32'hFFFF_FFFC);
    step("s3_ref2", 1, ADD, 0, 0, 0, 32'h0);
    step("s3_wrap", 1, ADD, 0, 0, 0, 32'h0);
    chk("s3_pc_wrap", pc, 32'h0);

    // hold for 5 cycles mid-WAIT with resolve pending
    do_reset("s4_rst");
    step("s4_beq", 1, BEQ, 0, 0, 0, 32'h0);
    step("s4_w1", 1, ADD, 0, 0, 0, 32'h0);
    for (int i = 0; i < 5; i++) step("s4_hold", 1, ADD, 1, 1, 1, 32'h80);
    chk("s4_hold_state", 32'(state_dbg), 32'd1);
    chk("s4_hold_pc", pc, 32'h4);
    chk("s4_hold_scnt", 32'(stall_cnt), 32'd1);
    step("s4_go", 1, ADD, 0, 1, 1, 32'h80);
    chk("s4_pc80", pc, 32'h80);
    chk("s4_refill", 32'(state_dbg), 32'd2);
    step("s4_ref", 1, ADD, 0, 0, 0, 32'h0);

    // Resolve on the timeout boundary wins; then a genuine timeout
    do_reset("s5_rst");
    step("s5_j", 1, J, 0, 0, 0, 32'h0);
    for (int i = 0; i < 7; i++) step("s5_w", 0, ADD, 0, 0, 0, 32'h0);
    step("s5_edge", 0, ADD, 0, 1, 1, 32'h200);
    chk("s5_edge_terr", 32'(timeout_err), 32'd0);
    chk("s5_edge_pc", pc, 32'h200);
    step("s5_ref", 0, ADD, 0, 0, 0, 32'h0);
    step("s5_j2", 1, J, 0, 0, 0, 32'h0);
    for (int i = 0; i < 8; i++) step("s5_to", 1, ADD, 0, 0, 0, 32'h0);
    chk("s5_terr", 32'(timeout_err), 32'd1);
    chk("s5_to_pc", pc, 32'h204);
    chk("s5_to_state", 32'(state_dbg), 32'd0);
    step("s5_spur", 0, ADD, 0, 1, 1, 32'h300);
    chk("s5_spur_pc", pc, 32'h204);
    step("s5_sticky", 1, ADD, 0, 0, 0, 32'h0);

    // Reset mid-WAIT and mid-REFILL, then counter saturation
    step("s6_beq", 1, BEQ, 0, 0, 0, 32'h0);
    step("s6_w1", 1, ADD, 0, 0, 0, 32'h0);
    do_reset("s6_rst_wait");
    step("s6_beq2", 1, BEQ, 0, 0, 0, 32'h0);
    step("s6_res", 1, ADD, 0, 1, 1, 32'h500);
    do_reset("s6_rst_refill");
    for (int i = 0; i < 20; i++) begin
      step("s6_j", 1, J, 0, 0, 0, 32'h0);
      step("s6_nt", 1, ADD, 0, 1, 0, 32'h0);
      step("s6_ref", 1, ADD, 0, 0, 0, 32'h0);
    end
    chk("s6_bcnt_sat", 32'(branch_cnt), 32'd15);
    chk("s6_scnt_sat", 32'(stall_cnt), 32'd15);
    chk("s6_pc", pc, 32'd80);
    step("s6_end", 0, ADD, 0, 0, 0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
